// File: rtl/BrLitePkg.sv
// BrLite link-level types shared by routers and the blocks that observe them.
package BrLitePkg;

  typedef logic [2:0] br_port_t;

  typedef struct packed {
    logic [15:0] seq_source;
    logic [15:0] target;
    logic [31:0] payload;
    logic [7:0]  ksvc;
    logic        clear;
  } br_data_t;

endpackage

// File: rtl/TrafficMonitorPkg.sv
// Record format produced by the BrLite traffic monitor.
package TrafficMonitorPkg;
  import BrLitePkg::*;

  localparam int TICK_W = 64;
  localparam int ADDR_W = 16;
  localparam int KSVC_W = 8;
  localparam int LAT_W  = 16;
  localparam int DIR_W  = 4;

  typedef logic [DIR_W-1:0] dir_t;

  typedef struct packed {
    logic [TICK_W-1:0] tick;
    logic [ADDR_W-1:0] address;
    logic [KSVC_W-1:0] ksvc;
    br_port_t          port;
    logic [LAT_W-1:0]  latency;
    dir_t              dir;
  } traffic_rec_t;

  // Direction code seen from the router: incoming side of port p is p*2+1.
  function automatic dir_t port_dir(br_port_t p);
    return {p, 1'b1};
  endfunction

endpackage

// File: rtl/traffic_rec_fifo.sv
// First-word-fall-through record FIFO; head output reads as zero while empty.
module traffic_rec_fifo #(
  parameter int  DEPTH = 8,
  parameter type rec_t = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  rec_t push_data_i,
  output logic full_o,
  input  logic pop_i,
  output logic valid_o,
  output rec_t data_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign valid_o = (count_reg != '0);
  assign full_o  = (count_reg == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop_i & valid_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = valid_o ? mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/br_traffic_monitor.sv
// Observes BrLite handshakes per port, timestamps acknowledged flits with their
// wait latency and queues them as records through a round-robin arbiter.
module br_traffic_monitor
  import BrLitePkg::*;
  import TrafficMonitorPkg::*;
#(
  parameter logic [15:0] ADDRESS   = 16'h0000,
  parameter int          NUM_PORTS = 5,
  parameter int          CNT_W     = 16,
  parameter int          DEPTH     = 8,
  parameter logic        LOG_CLEAR = 1'b0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_PORTS-1:0]           rx_i,
  input  logic [NUM_PORTS-1:0]           ack_rx_i,
  input  br_data_t [NUM_PORTS-1:0]       data_i,
  input  logic [63:0]                    tick_cntr_i,
  output logic                           rec_valid_o,
  input  logic                           rec_ready_i,
  output traffic_rec_t                   rec_o,
  output logic [15:0]                    drop_cnt_o
);

  logic [NUM_PORTS-1:0] event_w;
  logic [NUM_PORTS-1:0] grant_w;
  logic [NUM_PORTS-1:0] drop_w;
  logic [NUM_PORTS-1:0] slot_valid_w;
  traffic_rec_t         slot_rec_w [NUM_PORTS];

  br_port_t     rr_ptr_reg;
  br_port_t     win_port_w;
  logic         win_found_w;
  logic         transfer_w;
  logic         fifo_full_w;
  logic         fifo_pop_w;
  logic [15:0]  drop_cnt_reg;
  logic [15:0]  drop_cnt_next;
  logic [16:0]  drop_sum_w;
  logic         unused_data;

  // Only ksvc and clear of each flit are observed.
  assign unused_data = ^data_i;

  function automatic br_port_t rr_index(br_port_t base, int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return br_port_t'(sum);
  endfunction

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    localparam br_port_t PORT = br_port_t'(gi);

    logic [CNT_W-1:0] wait_cnt_reg;
    logic             slot_valid_reg;
    traffic_rec_t     slot_rec_reg;
    traffic_rec_t     capture_rec;

    assign event_w[gi]      = ack_rx_i[gi] & (~data_i[gi].clear | LOG_CLEAR);
    assign grant_w[gi]      = transfer_w & (win_port_w == PORT);
    // A slot draining this edge can take the new event instead of dropping it.
    assign drop_w[gi]       = event_w[gi] & slot_valid_reg & ~grant_w[gi];
    assign slot_valid_w[gi] = slot_valid_reg;
    assign slot_rec_w[gi]   = slot_rec_reg;

    always_comb begin
      capture_rec         = '0;
      capture_rec.tick    = tick_cntr_i;
      capture_rec.address = ADDRESS;
      capture_rec.ksvc    = data_i[gi].ksvc;
      capture_rec.port    = PORT;
      capture_rec.latency = LAT_W'(wait_cnt_reg);
      capture_rec.dir     = port_dir(PORT);
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wait_cnt_reg   <= '0;
        slot_valid_reg <= 1'b0;
        slot_rec_reg   <= '0;
      end else begin
        if (ack_rx_i[gi]) begin
          wait_cnt_reg <= '0;
        end else if (rx_i[gi] && (wait_cnt_reg != '1)) begin
          wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
        end

        if (event_w[gi] && (!slot_valid_reg || grant_w[gi])) begin
          slot_valid_reg <= 1'b1;
          slot_rec_reg   <= capture_rec;
        end else if (grant_w[gi]) begin
          slot_valid_reg <= 1'b0;
        end
      end
    end
  end

  // First occupied slot at or after the round-robin pointer wins.
  always_comb begin
    win_found_w = 1'b0;
    win_port_w  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!win_found_w && slot_valid_w[rr_index(rr_ptr_reg, i)]) begin
        win_found_w = 1'b1;
        win_port_w  = rr_index(rr_ptr_reg, i);
      end
    end
  end

  assign fifo_pop_w = rec_valid_o & rec_ready_i;
  assign transfer_w = win_found_w & (~fifo_full_w | fifo_pop_w);

  always_comb begin
    drop_sum_w    = {1'b0, drop_cnt_reg} + 17'($countones(drop_w));
    drop_cnt_next = drop_sum_w[16] ? 16'hFFFF : drop_sum_w[15:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_reg   <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (transfer_w) rr_ptr_reg <= rr_index(win_port_w, 1);
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign drop_cnt_o = drop_cnt_reg;

  traffic_rec_fifo #(
    .DEPTH (DEPTH),
    .rec_t (traffic_rec_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (transfer_w),
    .push_data_i (slot_rec_w[win_port_w]),
    .full_o      (fifo_full_w),
    .pop_i       (fifo_pop_w),
    .valid_o     (rec_valid_o),
    .data_o      (rec_o)
  );

endmodule
